// File: rtl/snn_classifier_pkg.sv
// Shared FSM state type and default configuration for the SNN spike classifier.
package snn_classifier_pkg;

    localparam int unsigned DefNumClasses  = 10;
    localparam int unsigned DefCntW        = 8;
    localparam int unsigned DefDrainCycles = 4;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StDrain,
        StScan,
        StDone
    } state_e;

endpackage

// File: rtl/snn_argmax_scan.sv
// Sequential argmax: one candidate count per cycle for indices 0..NUM_CLASSES-1. Only a strictly
// greater count replaces the best, so ties keep the lowest index and all-zero yields index 0.
module snn_argmax_scan
    import snn_classifier_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = DefNumClasses,
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned IDX_W       = $clog2(DefNumClasses)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [IDX_W-1:0] index,
    output logic             done,
    output logic [IDX_W-1:0] best_index,
    output logic [CNT_W-1:0] best_count
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

    logic             active_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] best_idx_q;
    logic [CNT_W-1:0] best_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= 1'b0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
        end else if (start) begin
            active_q   <= 1'b1;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
        end else if (active_q) begin
            if (count > best_cnt_q) begin
                best_idx_q <= idx_q;
                best_cnt_q <= count;
            end
            if (idx_q == LastIdx) begin
                active_q <= 1'b0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign index      = idx_q;
    assign done       = active_q && (idx_q == LastIdx);
    assign best_index = best_idx_q;
    assign best_count = best_cnt_q;

endmodule

// File: rtl/snn_spike_classifier.sv
// Counts output-neuron spike packets per class over a frame, drains the FIFO, then reports argmax.
// Define SNN_CLASSIFIER_SATURATE_EN to make per-class counters saturate instead of wrapping.
module snn_spike_classifier
    import snn_classifier_pkg::*;
#(
    parameter int unsigned NUM_CLASSES  = DefNumClasses,
    parameter int unsigned CNT_W        = DefCntW,
    parameter int unsigned DRAIN_CYCLES = DefDrainCycles
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     packet_out,
    input  logic                           packet_out_rempty,
    output logic                           packet_out_rinc,
    input  logic                           frame_start,
    input  logic                           frame_end,
    input  logic                           result_ack,
    output logic                           result_valid,
    output logic [$clog2(NUM_CLASSES)-1:0] result_class,
    output logic [CNT_W-1:0]               result_count,
    output logic [15:0]                    total_spikes,
    output logic                           busy,
    output logic                           range_error,
    output logic                           seq_error
);

    localparam int unsigned      IDX_W   = $clog2(NUM_CLASSES);
    localparam int unsigned      RUN_W   = $clog2(DRAIN_CYCLES + 1);
    localparam logic [RUN_W-1:0] RunLast = RUN_W'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
    logic [15:0]      total_q, total_d;
    logic             range_err_q, seq_err_q;
    logic             pop_en, clear, seq_set, scan_start, scan_done, in_range;
    logic [31:0]      pkt_val;
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] scan_count;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef SNN_CLASSIFIER_SATURATE_EN
        return (c == '1) ? c : c + CNT_W'(1);
`else
        return c + CNT_W'(1);
`endif
    endfunction

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        pop_en     = 1'b0;
        clear      = 1'b0;
        seq_set    = 1'b0;
        scan_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                seq_set = frame_end;
                if (frame_start) begin
                    clear   = 1'b1;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                pop_en = 1'b1;
                if (frame_start) begin
                    clear = 1'b1;
                end else if (frame_end) begin
                    state_d = StDrain;
                    run_d   = '0;
                end
            end
            StDrain: begin
                pop_en  = 1'b1;
                seq_set = frame_start | frame_end;
                if (!packet_out_rempty) begin
                    run_d = '0;
                end else if (run_q == RunLast) begin
                    run_d      = '0;
                    scan_start = 1'b1;
                    state_d    = StScan;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end
            StScan: begin
                seq_set = frame_start | frame_end;
                if (scan_done) state_d = StDone;
            end
            StDone: begin
                seq_set = frame_end;
                if (frame_start) begin
                    // Restart pops straight into the new frame.
                    pop_en  = 1'b1;
                    clear   = 1'b1;
                    state_d = StCollect;
                end else if (result_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign packet_out_rinc = pop_en & ~packet_out_rempty & ~reset;

    always_comb begin
        pkt_val  = 32'(packet_out);
        in_range = pkt_val < NUM_CLASSES;
        total_d  = clear ? '0 : total_q;
        if (packet_out_rinc && in_range && total_d != 16'hFFFF) begin
            total_d = total_d + 16'd1;
        end
        for (int i = 0; i < NUM_CLASSES; i++) begin
            cnt_d[i] = clear ? '0 : cnt_q[i];
            if (packet_out_rinc && pkt_val == i) cnt_d[i] = cnt_inc(cnt_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            run_q       <= '0;
            total_q     <= '0;
            range_err_q <= 1'b0;
            seq_err_q   <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            total_q     <= total_d;
            range_err_q <= range_err_q | (packet_out_rinc & ~in_range);
            seq_err_q   <= seq_err_q | seq_set;
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign scan_count = cnt_q[scan_idx];

    snn_argmax_scan #(
        .NUM_CLASSES(NUM_CLASSES),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) u_argmax (
        .clk       (clk),
        .reset     (reset),
        .start     (scan_start),
        .count     (scan_count),
        .index     (scan_idx),
        .done      (scan_done),
        .best_index(result_class),
        .best_count(result_count)
    );

    assign result_valid = (state_q == StDone);
    assign busy         = (state_q == StCollect) || (state_q == StDrain) || (state_q == StScan);
    assign total_spikes = total_q;
    assign range_error  = range_err_q;
    assign seq_error    = seq_err_q;

endmodule

// File: tb/tb_snn_spike_classifier.sv
// Randomized self-checking bench: bench-owned FIFO plus a frame-level reference model.
module tb_snn_spike_classifier;

    localparam int NC   = 10;
    localparam int CW   = 8;
    localparam int DC   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [7:0]            packet_out;
    logic                  packet_out_rempty;
    logic                  packet_out_rinc;
    logic                  frame_start, frame_end, result_ack;
    logic                  result_valid;
    logic [$clog2(NC)-1:0] result_class;
    logic [CW-1:0]         result_count;
    logic [15:0]           total_spikes;
    logic                  busy, range_error, seq_error;

    always #5 clk = ~clk;

    snn_spike_classifier #(
        .NUM_CLASSES (NC),
        .CNT_W       (CW),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .packet_out       (packet_out),
        .packet_out_rempty(packet_out_rempty),
        .packet_out_rinc  (packet_out_rinc),
        .frame_start      (frame_start),
        .frame_end        (frame_end),
        .result_ack       (result_ack),
        .result_valid     (result_valid),
        .result_class     (result_class),
        .result_count     (result_count),
        .total_spikes     (total_spikes),
        .busy             (busy),
        .range_error      (range_error),
        .seq_error        (seq_error)
    );

    typedef enum int {PIdle, PCollect, PDrain, PScan, PDone} phase_t;

    phase_t     phase;
    int         run, scan_left, mtotal;
    int         mcnt [NC];
    bit         mrng, mseq, chk_en;
    logic [7:0] fifo [$];
    int         n_chk, n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NC; i++) mcnt[i] = 0;
        mtotal = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        phase = PIdle;
        run = 0;
        scan_left = 0;
        mrng = 0;
        mseq = 0;
    endfunction

    function automatic void model_pop(input logic [7:0] v);
        if (v < NC) begin
`ifdef SNN_CLASSIFIER_SATURATE_EN
            mcnt[v] = (mcnt[v] == CMAX) ? CMAX : mcnt[v] + 1;
`else
            mcnt[v] = (mcnt[v] + 1) % (CMAX + 1);
`endif
            mtotal = (mtotal == 65535) ? 65535 : mtotal + 1;
        end else begin
            mrng = 1;
        end
    endfunction

    function automatic void argmax(output int cls, output int cnt);
        cls = 0;
        cnt = 0;
        for (int i = 0; i < NC; i++) if (mcnt[i] > cnt) begin cls = i; cnt = mcnt[i]; end
    endfunction

    function automatic void refresh();
        packet_out_rempty = (fifo.size() == 0);
        packet_out = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endfunction

    // One clock: sample inputs at the edge, then advance the model and FIFO just after it.
    task automatic tick();
        bit fs, fe, ack, rs, emp, do_pop;
        logic [7:0] v;
        @(posedge clk);
        fs = frame_start; fe = frame_end; ack = result_ack; rs = reset;
        emp = (fifo.size() == 0);
        do_pop = packet_out_rinc && !emp;
        #1;
        if (rs) begin
            model_reset();
        end else begin
            case (phase)
                PIdle: begin
                    if (fe) mseq = 1;
                    if (fs) begin model_clear(); phase = PCollect; end
                end
                PCollect: begin
                    if (fs) model_clear();
                    else if (fe) begin phase = PDrain; run = 0; end
                end
                PDrain: begin
                    if (fs || fe) mseq = 1;
                    if (emp) begin
                        run++;
                        if (run == DC) begin phase = PScan; scan_left = NC; end
                    end else run = 0;
                end
                PScan: begin
                    if (fs || fe) mseq = 1;
                    scan_left--;
                    if (scan_left == 0) phase = PDone;
                end
                PDone: begin
                    if (fe) mseq = 1;
                    if (fs) begin model_clear(); phase = PCollect; end
                    else if (ack) phase = PIdle;
                end
                default: ;
            endcase
        end
        if (do_pop) begin
            v = fifo.pop_front();
            if (!rs) model_pop(v);
        end
        refresh();
    endtask

    always @(negedge clk) begin
        int ecls, ecnt;
        bit exp_rinc;
        if (chk_en && !reset) begin
            exp_rinc = (fifo.size() != 0) && (phase == PCollect || phase == PDrain ||
                       (phase == PDone && frame_start));
            chk("busy", 32'(busy), 32'(phase == PCollect || phase == PDrain || phase == PScan));
            chk("result_valid", 32'(result_valid), 32'(phase == PDone));
            chk("rinc", 32'(packet_out_rinc), 32'(exp_rinc));
            chk("range_error", 32'(range_error), 32'(mrng));
            chk("seq_error", 32'(seq_error), 32'(mseq));
            chk("total_spikes", 32'(total_spikes), 32'(mtotal));
            if (phase == PDone) begin
                argmax(ecls, ecnt);
                chk("result_class", 32'(result_class), 32'(ecls));
                chk("result_count", 32'(result_count), 32'(ecnt));
            end
        end
    end

    task automatic push(input logic [7:0] v);
        fifo.push_back(v);
        refresh();
    endtask

    task automatic pulse_start();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic ack();
        result_ack = 1'b1; tick(); result_ack = 1'b0;
    endtask

    task automatic feed(input logic [7:0] pk [$], input int gap_max);
        foreach (pk[k]) begin
            push(pk[k]);
            tick();
            repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic wait_empty();
        int b = 0;
        while (fifo.size() > 0 && b < 400) begin tick(); b++; end
        chk("fifo_drained", 32'(fifo.size()), 32'd0);
    endtask

    task automatic close_frame(input bit illegal);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        for (int k = 0; k < DC + NC; k++) begin
            if (illegal && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) != 0) frame_start = 1'b1;
                else frame_end = 1'b1;
            end
            tick();
            frame_start = 1'b0;
            frame_end = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] pk [$];
        logic [7:0] v;
        int n;
        n_chk = 0; n_pass = 0; chk_en = 0;
        reset = 1'b1; frame_start = 1'b0; frame_end = 1'b0; result_ack = 1'b0;
        model_reset();
        refresh();
        tick(); tick();
        reset = 1'b0;
        chk_en = 1;
        #1;
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_total", 32'(total_spikes), 32'd0);
        chk("rst_rinc", 32'(packet_out_rinc), 32'd0);

        // 3,3,7,3,7 -> class 3 with 3 spikes, 5 total.
        pulse_start();
        pk = '{8'd3, 8'd3, 8'd7, 8'd3, 8'd7};
        feed(pk, 2);
        wait_empty();
        close_frame(0);
        chk("lit1_class", 32'(result_class), 32'd3);
        chk("lit1_count", 32'(result_count), 32'd3);
        chk("lit1_total", 32'(total_spikes), 32'd5);
        tick(); tick();
        chk("lit1_hold", 32'(result_valid), 32'd1);
        ack();

        // Tie between 2 and 5 resolves to the lower index.
        pulse_start();
        pk = '{8'd2, 8'd5, 8'd5, 8'd2};
        feed(pk, 1);
        wait_empty();
        close_frame(0);
        chk("tie_class", 32'(result_class), 32'd2);
        chk("tie_count", 32'(result_count), 32'd2);
        ack();

        // Out-of-range packet is discarded and flagged.
        pulse_start();
        pk = '{8'd1, 8'd12};
        feed(pk, 0);
        wait_empty();
        chk("rng_flag", 32'(range_error), 32'd1);
        chk("rng_total", 32'(total_spikes), 32'd1);
        close_frame(0);
        chk("rng_class", 32'(result_class), 32'd1);
        ack();

        // 300 spikes on one class: saturate or wrap.
        pulse_start();
        pk = {};
        for (int k = 0; k < 300; k++) pk.push_back(8'd4);
        feed(pk, 0);
        wait_empty();
        close_frame(0);
        chk("big_class", 32'(result_class), 32'd4);
`ifdef SNN_CLASSIFIER_SATURATE_EN
        chk("big_count", 32'(result_count), 32'd255);
`else
        chk("big_count", 32'(result_count), 32'd44);
`endif
        chk("big_total", 32'(total_spikes), 32'd300);
        ack();

        // Idle: FIFO is not popped; frame_end flags a sequence error.
        push(8'd6);
        tick(); tick(); tick();
        chk("idle_rinc", 32'(packet_out_rinc), 32'd0);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        chk("idle_seq", 32'(seq_error), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of a drain.
        pulse_start();
        pk = '{8'd8, 8'd8};
        feed(pk, 0);
        wait_empty();
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_valid", 32'(result_valid), 32'd0);
        chk("mrst_seq", 32'(seq_error), 32'd0);
        chk("mrst_rng", 32'(range_error), 32'd0);
        chk("mrst_total", 32'(total_spikes), 32'd0);
        pulse_start();
        pk = '{8'd1};
        feed(pk, 0);
        wait_empty();
        close_frame(0);
        chk("mrst_class", 32'(result_class), 32'd1);
        chk("mrst_count", 32'(result_count), 32'd1);
        ack();

        // frame_start coincident with a pop, in COLLECT and then in DONE.
        pulse_start();
        pk = '{8'd5, 8'd5};
        feed(pk, 0);
        wait_empty();
        push(8'd9);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        wait_empty();
        close_frame(0);
        chk("coin_class", 32'(result_class), 32'd9);
        chk("coin_count", 32'(result_count), 32'd1);
        push(8'd4);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        wait_empty();
        close_frame(0);
        chk("done_class", 32'(result_class), 32'd4);
        chk("done_total", 32'(total_spikes), 32'd1);
        ack();

        for (int f = 0; f < 15; f++) begin
            if (phase != PCollect) pulse_start();
            n = $urandom_range(0, 40);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 19) == 0) v = 8'($urandom_range(10, 255));
                else v = 8'($urandom_range(0, 9));
                push(v);
                tick();
                if ($urandom_range(0, 3) == 0) tick();
                if ($urandom_range(0, 30) == 0) pulse_start();
            end
            wait_empty();
            close_frame(1);
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) != 0) push(8'($urandom_range(0, 9)));
                pulse_start();
            end else begin
                ack();
            end
        end
        tick(); tick();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
